// File: rtl/int_wb_arbiter_pkg.sv
// Shared integer writeback types: widths, source ids, payload tag.
package int_wb_arbiter_pkg;

  localparam int ROB_IDX_W = 6;
  localparam int PREG_W    = 7;

  typedef enum logic [1:0] {
    SRC_MISC = 2'd0,
    SRC_ALU0 = 2'd1,
    SRC_ALU1 = 2'd2,
    SRC_MDU  = 2'd3
  } wb_src_e;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PREG_W-1:0]    preg;
    logic                 we;
  } wb_tag_t;

endpackage

// File: rtl/int_wb_arbiter_rr_pick2.sv
// Rotating-priority picker: first G valid sources from ptr onward,
// each as a one-hot grant with its index.
module int_wb_arbiter_rr_pick2 #(
  parameter int N  = 4,
  parameter int G  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]          valid,
  input  logic [PW-1:0]         ptr,
  output logic [G-1:0][N-1:0]   gnt,
  output logic [G-1:0]          gnt_v,
  output logic [G-1:0][PW-1:0]  gnt_idx
);

  int cnt;

  // Source j is at scan position k when ptr+k == j (mod N).
  always_comb begin
    gnt     = '0;
    gnt_v   = '0;
    gnt_idx = '0;
    cnt     = 0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (valid[j] &&
            (int'(ptr) + k == j || int'(ptr) + k == j + N)) begin
          for (int g = 0; g < G; g++) begin
            if (cnt == g) begin
              gnt[g][j]  = 1'b1;
              gnt_v[g]   = 1'b1;
              gnt_idx[g] = PW'(j);
            end
          end
          cnt = cnt + 1;
        end
      end
    end
  end

endmodule

// File: rtl/int_wb_arbiter.sv
// Integer writeback arbiter: NUM_SRC completed results onto
// NUM_PORT registered writeback ports, round-robin.
module int_wb_arbiter
  import int_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int NUM_PORT = 2,
  parameter int DATA_W   = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic [NUM_SRC-1:0]                 src_valid_i,
  input  logic [NUM_SRC-1:0][ROB_IDX_W-1:0]  src_rob_idx_i,
  input  logic [NUM_SRC-1:0][PREG_W-1:0]     src_preg_i,
  input  logic [NUM_SRC-1:0]                 src_we_i,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]     src_data_i,
  output logic [NUM_SRC-1:0]                 src_ready_o,
  output logic [NUM_PORT-1:0]                wb_valid_o,
  output logic [NUM_PORT-1:0][ROB_IDX_W-1:0] wb_rob_idx_o,
  output logic [NUM_PORT-1:0][PREG_W-1:0]    wb_preg_o,
  output logic [NUM_PORT-1:0]                wb_we_o,
  output logic [NUM_PORT-1:0][DATA_W-1:0]    wb_data_o
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PW-1:0]                    rr_ptr;
  logic [PW-1:0]                    last_idx;
  logic [PW-1:0]                    nxt_ptr;
  logic [NUM_PORT-1:0][NUM_SRC-1:0] gnt;
  logic [NUM_PORT-1:0]              gnt_v;
  logic [NUM_PORT-1:0][PW-1:0]      gnt_idx;
  logic                             take;
  wb_tag_t [NUM_PORT-1:0]           pay_tag;
  logic [NUM_PORT-1:0][DATA_W-1:0]  pay_data;

  int_wb_arbiter_rr_pick2 #(
    .N  (NUM_SRC),
    .G  (NUM_PORT),
    .PW (PW)
  ) u_pick (
    .valid   (src_valid_i),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_v   (gnt_v),
    .gnt_idx (gnt_idx)
  );

  assign take = !rst && !flush_i;

  always_comb begin
    src_ready_o = '0;
    last_idx    = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (gnt_v[p]) begin
        src_ready_o = src_ready_o | gnt[p];
        last_idx    = gnt_idx[p];
      end
    end
    if (!take) src_ready_o = '0;
  end

  // Explicit wrap so non-power-of-two source counts stay in range.
  assign nxt_ptr = (last_idx == PW'(NUM_SRC - 1)) ? '0
                                                  : last_idx + PW'(1);

  always_comb begin
    pay_tag  = '0;
    pay_data = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (gnt[p][j]) begin
          pay_tag[p].rob_idx = src_rob_idx_i[j];
          pay_tag[p].preg    = src_preg_i[j];
          pay_tag[p].we      = src_we_i[j];
          pay_data[p]        = src_data_i[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      wb_valid_o   <= '0;
      wb_rob_idx_o <= '0;
      wb_preg_o    <= '0;
      wb_we_o      <= '0;
      wb_data_o    <= '0;
    end else begin
      for (int p = 0; p < NUM_PORT; p++) begin
        wb_valid_o[p] <= take && gnt_v[p];
        if (take && gnt_v[p]) begin
          wb_rob_idx_o[p] <= pay_tag[p].rob_idx;
          wb_preg_o[p]    <= pay_tag[p].preg;
          wb_we_o[p]      <= pay_tag[p].we;
          wb_data_o[p]    <= pay_data[p];
        end
      end
      if (take && |gnt_v) rr_ptr <= nxt_ptr;
    end
  end

`ifndef SYNTHESIS
  if (NUM_PORT > 1) begin : g_chk
    a_rob_uniq: assert property (@(posedge clk) disable iff (rst)
      !(wb_valid_o[0] && wb_valid_o[1] &&
        wb_rob_idx_o[0] == wb_rob_idx_o[1]));
  end
`endif

endmodule
